// File: rtl/wb_slave_mem.sv
//------------------------------------------------------------------------------
// Module      : wb_slave_mem
// Description : Wishbone classic slave backed by a byte-writable 32-bit memory
//               with programmable wait states and out-of-range error replies.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_slave_mem #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_wb_adr,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    localparam int         c_AW   = $clog2(DEPTH);
    localparam logic [3:0] c_WC   = WAIT_CYCLES[3:0];
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [3:0]      r_cnt;
    logic [29:0]     r_adr;
    logic [3:0]      r_sel;
    logic            r_we;
    logic [31:0]     r_dat;
    logic            r_ack;
    logic            r_err;
    logic [31:0]     r_rdata;
    logic [31:0]     r_mem [DEPTH];

    logic            w_req;
    logic            w_idle;
    logic [29:0]     w_adr;
    logic [3:0]      w_sel;
    logic            w_we;
    logic [31:0]     w_dat;
    logic [3:0]      w_cnt_nxt;
    logic            w_wait_done;
    logic            w_go_resp;
    logic            w_in_range;
    logic [c_AW-1:0] w_idx;
    logic            w_wr_en;
    logic            w_unused;

    assign w_req  = i_wb_cyc & i_wb_stb;
    assign w_idle = (r_state == c_IDLE);

    // Zero-wait transfers resolve straight from the bus; otherwise from the latched copy.
    assign w_adr = w_idle ? i_wb_adr[31:2] : r_adr;
    assign w_sel = w_idle ? i_wb_sel       : r_sel;
    assign w_we  = w_idle ? i_wb_we        : r_we;
    assign w_dat = w_idle ? i_wb_dat       : r_dat;

    assign w_cnt_nxt   = r_cnt + 4'd1;
    assign w_wait_done = (r_state == c_WAIT) && i_wb_cyc && (w_cnt_nxt == c_WC);
    assign w_go_resp   = (w_idle && w_req && (c_WC == 4'd0)) || w_wait_done;

    assign w_in_range = ((w_adr >> c_AW) == 30'd0);
    assign w_idx      = w_adr[c_AW-1:0];
    assign w_wr_en    = w_go_resp & w_we & w_in_range & i_rst_n;

    assign w_unused = &{1'b0, i_wb_adr[1:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_adr   <= 30'd0;
            r_sel   <= 4'd0;
            r_we    <= 1'b0;
            r_dat   <= 32'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
            case (r_state)
                c_IDLE: begin
                    r_cnt <= 4'd0;
                    if (w_req) begin
                        r_adr   <= i_wb_adr[31:2];
                        r_sel   <= i_wb_sel;
                        r_we    <= i_wb_we;
                        r_dat   <= i_wb_dat;
                        r_state <= (c_WC == 4'd0) ? c_RESP : c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (!i_wb_cyc) begin
                        r_state <= c_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (w_cnt_nxt == c_WC) begin
                        r_state <= c_RESP;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
            if (w_go_resp) begin
                r_ack   <= w_in_range;
                r_err   <= ~w_in_range;
                r_rdata <= (w_in_range && !w_we) ? r_mem[w_idx] : 32'd0;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_sel[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_dat[8*b +: 8];
                end
            end
        end
    end

    assign o_wb_dat = r_rdata;
    assign o_wb_ack = r_ack;
    assign o_wb_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_wb_slave_mem.sv
//------------------------------------------------------------------------------
// Module      : tb_wb_slave_mem
// Description : Directed vector bench for wb_slave_mem (2-wait and 0-wait builds).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr, wdat, rdat;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack, err;
    logic [31:0] adr0, wdat0, rdat0;
    logic [3:0]  sel0;
    logic        we0, cyc0, stb0, ack0, err0;

    int n_chk  = 0;
    int n_fail = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    wb_slave_mem #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we),
        .i_wb_dat(wdat), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .o_wb_dat(rdat), .o_wb_ack(ack), .o_wb_err(err)
    );

    wb_slave_mem #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr0), .i_wb_sel(sel0), .i_wb_we(we0),
        .i_wb_dat(wdat0), .i_wb_cyc(cyc0), .i_wb_stb(stb0),
        .o_wb_dat(rdat0), .o_wb_ack(ack0), .o_wb_err(err0)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_ack;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge following the termination.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic g_ack, output logic g_err,
                        output logic [31:0] g_dat, output int lat);
        we = w; adr = a; sel = s; wdat = d; cyc = 1'b1; stb = 1'b1;
        g_ack = 1'b0; g_err = 1'b0; g_dat = 32'd0; lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ack || err) begin
                g_ack = ack; g_err = err; g_dat = rdat; lat = n;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        if (lat == 0) begin
            n_chk++; n_fail++;
            $display("FAIL xfer_timeout: adr %h got no termination, required one within 20 cycles", a);
        end
        @(posedge clk); #1;
        check("term_one_cycle", {30'd0, ack, err}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            n_chk++;
            if ($isunknown({rdat, ack, err, rdat0, ack0, err0}) || (ack && err) || (ack0 && err0) ||
                (!ack && rdat != 32'd0) || (!ack0 && rdat0 != 32'd0)) begin
                n_fail++;
                $display("FAIL monitor: ack=%b err=%b dat=%h ack0=%b err0=%b dat0=%h, required no X, no ack&err, dat 0 when ack low",
                         ack, err, rdat, ack0, err0, rdat0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        g_ack, g_err, seen;
        logic [31:0] g_dat;
        int          lat;

        vecs[0]  = '{1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 1'b1, 32'h0};
        vecs[1]  = '{1'b0, 32'h10,       4'hF, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h20,       4'hF, 32'h11223344, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 32'h20,       4'h5, 32'hAABBCCDD, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 32'h20,       4'hF, 32'h0,        1'b1, 32'h11BB33DD};
        vecs[5]  = '{1'b1, 32'h0,        4'hF, 32'hCAFEF00D, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 32'h400,      4'hF, 32'h12345678, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 32'hCAFEF00D};
        vecs[8]  = '{1'b0, 32'h400,      4'hF, 32'h0,        1'b0, 32'h0};
        vecs[9]  = '{1'b1, 32'h23,       4'h0, 32'h99999999, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h22,       4'hF, 32'h0,        1'b1, 32'h11BB33DD};
        vecs[11] = '{1'b1, 32'h3FC,      4'hF, 32'hF0F0F0F0, 1'b1, 32'h0};
        vecs[12] = '{1'b1, 32'h3FC,      4'h8, 32'h01020304, 1'b1, 32'h0};
        vecs[13] = '{1'b0, 32'h3FF,      4'hF, 32'h0,        1'b1, 32'h01F0F0F0};
        vecs[14] = '{1'b0, 32'hFFFFFFFC, 4'hF, 32'h0,        1'b0, 32'h0};
        vecs[15] = '{1'b1, 32'h30,       4'hF, 32'h55AA55AA, 1'b1, 32'h0};
        vecs[16] = '{1'b1, 32'h40,       4'hF, 32'h13579BDF, 1'b1, 32'h0};
        vecs[17] = '{1'b1, 32'h54,       4'hF, 32'h77777777, 1'b1, 32'h0};
        vecs[18] = '{1'b1, 32'h401,      4'hF, 32'hFFFFFFFF, 1'b0, 32'h0};
        vecs[19] = '{1'b0, 32'h10,       4'h3, 32'h0,        1'b1, 32'hDEADBEEF};

        rst_n = 1'b0;
        adr = 0; sel = 0; we = 0; wdat = 0; cyc = 0; stb = 0;
        adr0 = 0; sel0 = 0; we0 = 0; wdat0 = 0; cyc0 = 0; stb0 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {rdat[29:0], ack, err}, 32'd0);
        check("reset_outputs0", {rdat0[29:0], ack0, err0}, 32'd0);

        // First request is presented right as reset releases.
        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, g_ack, g_err, g_dat, lat);
            check($sformatf("v%0d_ack", i), {31'd0, g_ack}, {31'd0, vecs[i].exp_ack});
            check($sformatf("v%0d_err", i), {31'd0, g_err}, {31'd0, ~vecs[i].exp_ack});
            check($sformatf("v%0d_dat", i), g_dat, vecs[i].exp_dat);
            check($sformatf("v%0d_latency", i), lat, 32'd3);
        end

        // Abort: cyc drops during the first wait cycle.
        we = 1'b1; adr = 32'h30; sel = 4'hF; wdat = 32'h0BADF00D; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (ack || err) seen = 1'b1; end
        check("abort_no_term", {31'd0, seen}, 32'd0);
        xfer(1'b0, 32'h30, 4'hF, 32'h0, g_ack, g_err, g_dat, lat);
        check("abort_word_kept", g_dat, 32'h55AA55AA);

        // Reset while waiting on a write.
        we = 1'b1; adr = 32'h40; sel = 4'hF; wdat = 32'hFFFFFFFF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_wait_outputs", {rdat[29:0], ack, err}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (ack || err) seen = 1'b1; end
        check("rst_wait_no_ack", {31'd0, seen}, 32'd0);
        xfer(1'b0, 32'h40, 4'hF, 32'h0, g_ack, g_err, g_dat, lat);
        check("rst_wait_word_kept", g_dat, 32'h13579BDF);

        // Reset during the response cycle clears outputs asynchronously.
        we = 1'b0; adr = 32'h10; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin @(posedge clk); #1; seen = ack; end
        check("resp_ack_seen", {31'd0, seen}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_resp_outputs", {rdat[29:0], ack, err}, 32'd0);
        check("rst_resp_dat", rdat, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Bus changes after acceptance are ignored.
        we = 1'b1; adr = 32'h50; sel = 4'hF; wdat = 32'hA5A5A5A5; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        adr = 32'h54; wdat = 32'h0; sel = 4'h0; we = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin @(posedge clk); #1; seen = ack; end
        check("latch_ack", {31'd0, seen}, 32'd1);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 32'h50, 4'hF, 32'h0, g_ack, g_err, g_dat, lat);
        check("latch_word", g_dat, 32'hA5A5A5A5);
        xfer(1'b0, 32'h54, 4'hF, 32'h0, g_ack, g_err, g_dat, lat);
        check("latch_other_word", g_dat, 32'h77777777);

        // Zero-wait build: held strobe terminates every other cycle.
        we0 = 1'b1; adr0 = 32'h8; sel0 = 4'hF; wdat0 = 32'h12345678; cyc0 = 1'b1; stb0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_wr_ack%0d", i), {31'd0, ack0}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        we0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_rd_ack%0d", i), {31'd0, ack0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("b2b_rd_dat%0d", i), rdat0, (i % 2 == 0) ? 32'h12345678 : 32'd0);
        end
        cyc0 = 1'b0; stb0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
